// File: rtl/prefetch_queue_if.sv
// Handshake bundle for prefetch_queue: fetch request, in-order memory response, redirect, decode output.
// Latency: none, wires only.
// Backpressure: carried by req_ready (memory side) and out_ready (decode side).
interface prefetch_queue_if #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 32
);
    logic              req_valid;
    logic [AWIDTH-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_data;
    logic              flush;
    logic [AWIDTH-1:0] flush_addr;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [AWIDTH-1:0] out_pc;
    logic              out_ready;

    // Prefetch block's view.
    modport slave (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, flush, flush_addr,
        output out_valid, out_data, out_pc,
        input  out_ready
    );

    // Surrounding memory/decode view.
    modport master (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, flush, flush_addr,
        input  out_valid, out_data, out_pc,
        output out_ready
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch: sequential fetch requests, in-order responses queued with their PC, valid/ready to decode.
// Latency: rsp_valid -> out_valid 1 cycle; 0 cycles on an empty queue when built with PFQ_BYPASS_EN.
// Backpressure: a request issues only while queued + in-flight < DEPTH, so a stalled decode throttles fetch.
module prefetch_queue #(
    parameter int                WIDTH    = 32,
    parameter int                AWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter int                INC      = 4,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             resetn,
    prefetch_queue_if.slave bus
);
    localparam int                CW      = $clog2(DEPTH + 1);
    localparam int                PW      = $clog2(DEPTH);
    localparam logic [CW:0]       CREDITS = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]     ONE     = CW'(1);
    localparam logic [PW-1:0]     PONE    = PW'(1);
    localparam logic [AWIDTH-1:0] STEP    = AWIDTH'(INC);

    // Queue storage: instruction word and the PC it was fetched from.
    logic [WIDTH-1:0]  q_data [DEPTH];
    logic [AWIDTH-1:0] q_pc   [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // count: queued words; inflight: accepted requests without response;
    // drop: how many of the in-flight responses are stale from before a flush.
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     inflight_next;
    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] rsp_pc;

    logic q_empty;
    logic req_valid_int;
    logic req_fire;
    logic rsp_keep;
    logic bypass;
    logic bypass_take;
    logic push;
    logic pop;

    assign q_empty = (count == '0);

    // Fetch credit counts both buffered words and words still owed by memory,
    // which is what guarantees the queue can never overflow.
    assign req_valid_int = resetn & ~bus.flush
                         & (({1'b0, count} + {1'b0, inflight}) < CREDITS);
    assign req_fire      = req_valid_int & bus.req_ready;

    // A response is kept only when no stale responses are still outstanding.
    assign rsp_keep = bus.rsp_valid & (drop == '0);

`ifdef PFQ_BYPASS_EN
    assign bypass = resetn & q_empty & rsp_keep & ~bus.flush;
`else
    assign bypass = 1'b0;
`endif
    assign bypass_take = bypass & bus.out_ready;

    // Flush wins over both queue write and queue read in its cycle.
    assign push = rsp_keep & ~bus.flush & ~bypass_take;
    assign pop  = ~q_empty & bus.out_ready & ~bus.flush;

    assign bus.req_valid = req_valid_int;
    assign bus.req_addr  = fetch_pc;
    assign bus.out_valid = resetn & (~q_empty | bypass);

    // Output word: head of queue, or the live response when bypassing an empty queue.
    always_comb begin
        bus.out_data = '0;
        bus.out_pc   = '0;
        if (resetn) begin
            if (!q_empty) begin
                bus.out_data = q_data[rd_ptr];
                bus.out_pc   = q_pc[rd_ptr];
            end else if (bypass) begin
                bus.out_data = bus.rsp_data;
                bus.out_pc   = rsp_pc;
            end
        end
    end

    // Outstanding request count after this cycle's request and response.
    always_comb begin
        inflight_next = inflight;
        case ({req_fire, bus.rsp_valid})
            2'b10:   inflight_next = inflight + ONE;
            2'b01:   inflight_next = inflight - ONE;
            default: inflight_next = inflight;
        endcase
    end

    // Queue payload write; no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= bus.rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE;
            if (pop)  rd_ptr <= rd_ptr + PONE;
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // In-flight and stale-response bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (bus.flush) begin
                // Every request still owed after this cycle predates the redirect.
                drop <= inflight_next;
            end else if (bus.rsp_valid && (drop != '0)) begin
                drop <= drop - ONE;
            end
        end
    end

    // Fetch address and the PC tagged onto the next kept response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
        end else if (bus.flush) begin
            fetch_pc <= bus.flush_addr;
            rsp_pc   <= bus.flush_addr;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
        end
    end

    // Bookkeeping invariants: credit never exceeded, stale count bounded, no unsolicited responses.
    a_credit: assert property (@(posedge clk) disable iff (!resetn)
        ({1'b0, count} + {1'b0, inflight}) <= CREDITS);
    a_drop: assert property (@(posedge clk) disable iff (!resetn)
        drop <= inflight);
    a_rsp: assert property (@(posedge clk) disable iff (!resetn)
        bus.rsp_valid |-> (inflight != '0));

endmodule
